// File: rtl/affine_pkg.sv
// rtl/affine_pkg.sv - shared types, widths and states for the affine job controller
package affine_pkg;

  localparam int MV_W    = 13;
  localparam int COORD_W = 12;
  localparam int SIZE_W  = 9;
  localparam int COST_W  = 21;
  localparam int LAMB_W  = 9;
  localparam int MODE_W  = 3;

  localparam logic [COST_W-1:0] COST_MAX = {COST_W{1'b1}};

  typedef struct packed {
    logic signed [MV_W-1:0] mv_lt_x;
    logic signed [MV_W-1:0] mv_lt_y;
    logic signed [MV_W-1:0] mv_rt_x;
    logic signed [MV_W-1:0] mv_rt_y;
    logic signed [MV_W-1:0] mv_lb_x;
    logic signed [MV_W-1:0] mv_lb_y;
    logic [COORD_W-1:0]     ipu_x;
    logic [COORD_W-1:0]     ipu_y;
    logic [SIZE_W-1:0]      ipu_w;
    logic [SIZE_W-1:0]      ipu_h;
    logic                   iref_scale;
    logic                   large_mv_grad;
    logic [COST_W-1:0]      bits;
    logic [LAMB_W-1:0]      lamb;
    logic [COST_W-1:0]      rdcost_hevc;
  } affine_job_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GAP,
    ST_CALC,
    ST_WAIT,
    ST_RESP
  } ctrl_state_t;

endpackage

// File: rtl/affine_job_ctrl_if.sv
// rtl/affine_job_ctrl_if.sv - job, core and result signals of the affine job controller
interface affine_job_ctrl_if;
  import affine_pkg::*;

  logic                job_valid;
  logic                job_ready;
  affine_job_t         job;
  affine_job_t         aff_job;
  logic                aff_start_load;
  logic                aff_start_calc;
  logic                aff_done;
  logic [COST_W-1:0]   aff_cost_min;
  logic [MODE_W-1:0]   aff_mode;
  logic                res_valid;
  logic                res_ready;
  logic [COST_W-1:0]   res_cost;
  logic [MODE_W-1:0]   res_mode;
  logic                res_timeout;
  logic                busy;
  logic [15:0]         job_count;

  // slave is the controller; master is the job source, core and result consumer
  modport slave (
    input  job_valid, job, aff_done, aff_cost_min, aff_mode, res_ready,
    output job_ready, aff_job, aff_start_load, aff_start_calc,
           res_valid, res_cost, res_mode, res_timeout, busy, job_count
  );

  modport master (
    output job_valid, job, aff_done, aff_cost_min, aff_mode, res_ready,
    input  job_ready, aff_job, aff_start_load, aff_start_calc,
           res_valid, res_cost, res_mode, res_timeout, busy, job_count
  );

endinterface

// File: rtl/affine_watchdog.sv
// rtl/affine_watchdog.sv - WAIT-state cycle watchdog, built only with AFFINE_TIMEOUT_EN
`ifdef AFFINE_TIMEOUT_EN
module affine_watchdog #(
  parameter int WAIT_MAX = 4095
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic expired
);

  localparam logic [11:0] LAST = 12'(WAIT_MAX - 1);

  logic [11:0] cnt_q, cnt_d;

  // Counter restarts from zero whenever the controller is outside WAIT
  always_comb begin
    cnt_d = '0;
    if (en) cnt_d = cnt_q + 12'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = en && (cnt_q == LAST);

endmodule
`endif

// File: rtl/affine_job_ctrl.sv
// rtl/affine_job_ctrl.sv - load/calc sequencer and result holder for the affine core
// Optional WAIT watchdog enabled by AFFINE_TIMEOUT_EN.
module affine_job_ctrl
  import affine_pkg::*;
#(
  parameter int LOAD_GAP = 1,
  parameter int WAIT_MAX = 4095
) (
  input logic         clk,
  input logic         rst,
  affine_job_ctrl_if.slave bus
);

  if (LOAD_GAP < 1 || LOAD_GAP > 15) begin : g_bad_gap
    $error("LOAD_GAP must be 1..15");
  end
  if (WAIT_MAX < 1 || WAIT_MAX > 4095) begin : g_bad_wait
    $error("WAIT_MAX must be 1..4095");
  end

  localparam logic [3:0] GAP_LAST = 4'(LOAD_GAP - 1);

  ctrl_state_t       state_q, state_d;
  logic [3:0]        gap_q, gap_d;
  affine_job_t       job_q, job_d;
  logic [COST_W-1:0] res_cost_q, res_cost_d;
  logic [MODE_W-1:0] res_mode_q, res_mode_d;
  logic              res_timeout_q, res_timeout_d;
  logic [15:0]       job_count_q, job_count_d;
  logic              wd_expired;

`ifdef AFFINE_TIMEOUT_EN
  affine_watchdog #(
    .WAIT_MAX (WAIT_MAX)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q == ST_WAIT),
    .expired (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    gap_d         = gap_q;
    job_d         = job_q;
    res_cost_d    = res_cost_q;
    res_mode_d    = res_mode_q;
    res_timeout_d = res_timeout_q;
    job_count_d   = job_count_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.job_valid) begin
          job_d   = bus.job;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        gap_d   = '0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_CALC;
        else                   gap_d   = gap_q + 4'd1;
      end
      ST_CALC: state_d = ST_WAIT;
      ST_WAIT: begin
        // A done coinciding with watchdog expiry is a real result
        if (bus.aff_done) begin
          res_cost_d    = bus.aff_cost_min;
          res_mode_d    = bus.aff_mode;
          res_timeout_d = 1'b0;
          state_d       = ST_RESP;
        end else if (wd_expired) begin
          res_cost_d    = COST_MAX;
          res_mode_d    = '0;
          res_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.res_ready) begin
          job_count_d = job_count_q + 16'd1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      gap_q         <= '0;
      job_q         <= '0;
      res_cost_q    <= '0;
      res_mode_q    <= '0;
      res_timeout_q <= 1'b0;
      job_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      job_q         <= job_d;
      res_cost_q    <= res_cost_d;
      res_mode_q    <= res_mode_d;
      res_timeout_q <= res_timeout_d;
      job_count_q   <= job_count_d;
    end
  end

  assign bus.job_ready      = (state_q == ST_IDLE);
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.aff_start_load = (state_q == ST_LOAD);
  assign bus.aff_start_calc = (state_q == ST_CALC);
  assign bus.res_valid      = (state_q == ST_RESP);
  assign bus.aff_job        = job_q;
  assign bus.res_cost       = res_cost_q;
  assign bus.res_mode       = res_mode_q;
  assign bus.res_timeout    = res_timeout_q;
  assign bus.job_count      = job_count_q;

endmodule
